// File: rtl/spm_pkg.sv
// ============================================================================
// Module : spm_pkg
// Brief  : Shared widths and FSM state encoding for the signed multiplier.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package spm_pkg;

    localparam int SPM_OP_W   = 8;
    localparam int SPM_PROD_W = 16;
    localparam int SPM_CNT_W  = 3;

    typedef logic [1:0] spm_state_t;

    localparam spm_state_t IDLE = 2'd0;
    localparam spm_state_t LOAD = 2'd1;
    localparam spm_state_t MULT = 2'd2;
    localparam spm_state_t FIX  = 2'd3;

    // Magnitude of a two's-complement operand; -128 maps to 8'h80 (128).
    function automatic logic [SPM_OP_W-1:0] spm_abs(input logic [SPM_OP_W-1:0] v);
        return v[SPM_OP_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spm_sign_ctrl_if.sv
// ============================================================================
// Module : spm_sign_ctrl_if
// Brief  : Request/result bundle between a requester and spm_sign_ctrl.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface spm_sign_ctrl_if;
    import spm_pkg::*;

    logic                  start;
    logic [SPM_OP_W-1:0]   a;
    logic [SPM_OP_W-1:0]   b;
    logic                  busy;
    logic                  done;
    logic [SPM_PROD_W-1:0] product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

`default_nettype wire

// File: rtl/spm_mag_core.sv
// ============================================================================
// Module : spm_mag_core
// Brief  : Unsigned shift-add datapath, one multiplier bit per step, LSB first.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spm_mag_core
    import spm_pkg::*;
(
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  load,
    input  wire logic                  step,
    input  wire logic [SPM_OP_W-1:0]   op_a,
    input  wire logic [SPM_OP_W-1:0]   op_b,
    output logic      [SPM_PROD_W-1:0] acc,
    output logic      [SPM_CNT_W-1:0]  count
);

    logic [SPM_OP_W-1:0]   r_mag_a;
    logic [SPM_OP_W-1:0]   r_mag_b;
    logic [SPM_PROD_W-1:0] r_acc;
    logic [SPM_CNT_W-1:0]  r_count;
    logic [SPM_PROD_W-1:0] w_addend;

    assign w_addend = {{(SPM_PROD_W-SPM_OP_W){1'b0}}, r_mag_a} << r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_acc   <= '0;
            r_count <= '0;
        end else if (load) begin
            r_mag_a <= spm_abs(op_a);
            r_mag_b <= spm_abs(op_b);
            r_acc   <= '0;
            r_count <= '0;
        end else if (step) begin
            // 128*128 fits in 16 bits, so the unsigned sum never overflows.
            if (r_mag_b[r_count])
                r_acc <= r_acc + w_addend;
            r_count <= r_count + 1'b1;
        end
    end

    assign acc   = r_acc;
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/spm_sign_ctrl.sv
// ============================================================================
// Module : spm_sign_ctrl
// Brief  : Sequential signed 8x8 multiplier: sign-magnitude shift-add, 10-cycle
//          latency. Define SPM_ZERO_SKIP_EN to shortcut zero operands to FIX.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spm_sign_ctrl
    import spm_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst_n,
    spm_sign_ctrl_if.slave     bus
);

    spm_state_t            r_state;
    logic [SPM_OP_W-1:0]   r_a;
    logic [SPM_OP_W-1:0]   r_b;
    logic                  r_neg;
    logic                  r_busy;
    logic                  r_done;
    logic [SPM_PROD_W-1:0] r_product;

    logic [SPM_PROD_W-1:0] w_acc;
    logic [SPM_CNT_W-1:0]  w_count;
    logic [SPM_PROD_W-1:0] w_signed;
    logic                  w_load;
    logic                  w_step;

    assign w_load = (r_state == LOAD);
    assign w_step = (r_state == MULT);

    // Negating a zero accumulator yields zero, so no negative-zero case exists.
    assign w_signed = r_neg ? (~w_acc + 1'b1) : w_acc;

`ifdef SPM_ZERO_SKIP_EN
    logic w_zero;
    assign w_zero = (r_a == '0) || (r_b == '0);
`endif

    spm_mag_core u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .step  (w_step),
        .op_a  (r_a),
        .op_b  (r_b),
        .acc   (w_acc),
        .count (w_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_neg     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_busy  <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_neg <= r_a[SPM_OP_W-1] ^ r_b[SPM_OP_W-1];
`ifdef SPM_ZERO_SKIP_EN
                    r_state <= w_zero ? FIX : MULT;
`else
                    r_state <= MULT;
`endif
                end
                MULT: begin
                    if (w_count == {SPM_CNT_W{1'b1}})
                        r_state <= FIX;
                end
                FIX: begin
                    r_product <= w_signed;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;

endmodule

`default_nettype wire

// File: tb/tb_spm_sign_ctrl.sv
// ============================================================================
// Module : tb_spm_sign_ctrl
// Brief  : Directed self-checking bench for spm_sign_ctrl (honours SPM_ZERO_SKIP_EN).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_spm_sign_ctrl;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

`ifdef SPM_ZERO_SKIP_EN
    localparam int ZERO_LAT = 2;
`else
    localparam int ZERO_LAT = 10;
`endif

    spm_sign_ctrl_if bus ();

    spm_sign_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one multiply; count edges from the accepting edge to the done pulse.
    task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                          input logic [15:0] expp, input int explat);
        int          lat;
        logic        seen;
        logic        held;
        logic [15:0] p0;
        @(negedge clk);
        bus.a = va; bus.b = vb; bus.start = 1'b1;
        p0 = bus.product;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.a = ~va; bus.b = ~vb;
        check({tag, " busy_after_start"}, {31'b0, bus.busy}, 32'd1);
        lat = 0; seen = 1'b0; held = 1'b1;
        while (!seen && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            else if (bus.product !== p0) held = 1'b0;
        end
        check({tag, " latency"}, lat, explat);
        check({tag, " product"}, {16'b0, bus.product}, {16'b0, expp});
        check({tag, " busy_at_done"}, {31'b0, bus.busy}, 32'd0);
        check({tag, " product_held"}, {31'b0, held}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check({tag, " done_one_cycle"}, {31'b0, bus.done}, 32'd0);
    endtask

    initial begin
        int ndone;
        int kfirst;
        int didx[3];
        logic [15:0] dprod[3];

        tests = 0; fails = 0;
        rst_n = 1'b0;
        bus.start = 1'b1; bus.a = 8'd5; bus.b = 8'd5;

        // Reset with start asserted: start must be discarded.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst busy", {31'b0, bus.busy}, 32'd0);
        check("rst done", {31'b0, bus.done}, 32'd0);
        check("rst product", {16'b0, bus.product}, 32'd0);
        bus.start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("idle after release", {31'b0, bus.busy}, 32'd0);

        run_op("13x11", 8'd13, 8'd11, 16'd143, 10);
        run_op("m128xm128", 8'h80, 8'h80, 16'h4000, 10);
        run_op("m128x127", 8'h80, 8'h7F, 16'hC080, 10);
        run_op("m7x0", 8'hF9, 8'h00, 16'h0000, ZERO_LAT);

        // start pulsed at E4 while in MULT must be ignored.
        @(negedge clk);
        bus.a = 8'd5; bus.b = 8'd6; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        ndone = 0; kfirst = -1;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 3) bus.start = 1'b1;
            if (k == 4) bus.start = 1'b0;
            if (bus.done) begin
                ndone++;
                if (kfirst < 0) begin
                    kfirst = k;
                    check("e4 product", {16'b0, bus.product}, 32'd30);
                end
            end
        end
        check("e4 done count", ndone, 1);
        check("e4 done edge", kfirst, 10);

        // start held continuously: one result every 11 cycles.
        @(negedge clk);
        bus.a = 8'd3; bus.b = 8'hFB; bus.start = 1'b1;
        @(posedge clk);
        ndone = 0;
        for (int k = 1; k <= 60 && ndone < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                didx[ndone]  = k;
                dprod[ndone] = bus.product;
                ndone++;
                if (ndone == 3) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check("b2b done count", ndone, 3);
        if (ndone == 3) begin
            check("b2b done0 edge", didx[0], 10);
            check("b2b done1 edge", didx[1], 21);
            check("b2b done2 edge", didx[2], 32);
            for (int i = 0; i < 3; i++)
                check($sformatf("b2b product%0d", i), {16'b0, dprod[i]}, 32'h0000FFF1);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("b2b idle after", {31'b0, bus.busy}, 32'd0);

        // Reset at E6 aborts without a done pulse.
        bus.a = 8'd9; bus.b = 8'd9; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort busy", {31'b0, bus.busy}, 32'd0);
        check("abort done", {31'b0, bus.done}, 32'd0);
        check("abort product", {16'b0, bus.product}, 32'd0);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("abort no done", ndone, 0);
        run_op("2x2", 8'd2, 8'd2, 16'd4, 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spm_sign_ctrl.md
SPM_SIGN_CTRL -- requirements
Module: spm_sign_ctrl

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset: clk (posedge) and rst_n, sampled only on the rising edge of clk.
REQ-002 The module SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-004 The module SHALL have port start, input, 1 bit: request one multiply, sampled only in IDLE.
REQ-005 The module SHALL have port a, input, 8 bits: signed two's-complement multiplicand, captured at start.
REQ-006 The module SHALL have port b, input, 8 bits: signed two's-complement multiplier, captured at start.
REQ-007 The module SHALL have port busy, output, 1 bit: high from the edge after start is accepted until done.
REQ-008 The module SHALL have port done, output, 1 bit: one-cycle pulse, product valid.
REQ-009 The module SHALL have port product, output, 16 bits: signed a*b, held until the next done.

Function
REQ-010 FSM states SHALL be IDLE, LOAD, MULT, FIX; unused encodings SHALL return to IDLE on the next edge.
REQ-011 Edge E0: IDLE with start=1 -> capture a, b; go to LOAD; busy=1.
REQ-012 start SHALL be ignored outside IDLE; a and b SHALL be don't-care after E0.
REQ-013 LOAD (E1) register: mag_a=|a|, mag_b=|b| (8-bit unsigned; |-128| = 128); neg = a[7]^b[7]; acc (16 bits) = 0; count = 0; go to MULT.
REQ-014 Each MULT edge processes bit mag_b[count], LSB first: if set, acc += mag_a << count (16-bit unsigned, no overflow possible); count increments.
REQ-015 MULT SHALL last exactly 8 edges (E2..E9), leaving on count==7 for FIX.
REQ-016 FIX (E10) SHALL register product = neg ? (~acc + 1) : acc, pulse done=1, clear busy, and return to IDLE.
REQ-017 Latency from start sampled to done high SHALL be exactly 10 clock cycles.
REQ-018 A start sampled during the done cycle SHALL be accepted, since the state is IDLE; back-to-back throughput is one result per 11 cycles.
REQ-019 product SHALL change only at FIX; it SHALL NOT change during LOAD or MULT.
REQ-020 A negative-zero result (neg=1, acc=0) SHALL produce product=0.

Reset
REQ-021 rst_n=0 at an edge SHALL force state=IDLE, busy=0, done=0, product=0, acc=0, count=0, neg=0, mag_a=0, mag_b=0.
REQ-022 Reset mid-operation SHALL abort without any done pulse; the next start after release SHALL behave normally.
REQ-023 start sampled in the same edge as rst_n=0 SHALL be discarded.

Configuration
REQ-024 Macro SPM_ZERO_SKIP_EN, when defined, SHALL make LOAD detect mag_a==0 or mag_b==0 and go directly to FIX with acc=0, giving latency 2.
REQ-025 Without SPM_ZERO_SKIP_EN, zero operands SHALL take the full 10-cycle path and produce product=0.

Structure
REQ-026 Shared package spm_pkg SHALL hold SPM_OP_W=8, SPM_PROD_W=16, SPM_CNT_W=3, and the state typedef spm_state_t.
REQ-027 The shift-add datapath (mag_a, mag_b, acc, count) SHALL be a sub-module spm_mag_core, with load/step controls driven by the FSM in spm_sign_ctrl.
REQ-028 The conditional negation SHALL be combinational inside spm_sign_ctrl, registered into product at FIX.

Verification
REQ-029 The bench SHALL cover: a=8'd13, b=8'd11, start at E0 -> busy for 10 cycles, then done at E10 with product=16'd143.
REQ-030 The bench SHALL cover: a=-128, b=-128 -> product=16'h4000 (16384); and a=-128, b=127 -> product=16'hC080 (-16256).
REQ-031 The bench SHALL cover: a=-7, b=0 -> product=0, no negative zero; latency 10 without the macro and 2 with SPM_ZERO_SKIP_EN.
REQ-032 The bench SHALL cover: start pulsed at E4 during MULT -> ignored, with a single done at E10.
REQ-033 The bench SHALL cover: start held high continuously with a=3, b=-5 -> done every 11 cycles with product=16'hFFF1 (-15).
REQ-034 The bench SHALL cover: rst_n=0 at E6 -> next cycle all outputs 0 and no done; a fresh start with a=2, b=2 -> product=4.
